// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register countdown scoreboard detecting RAW / load-use hazards
//            for a forwarding pipeline, with a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_W  = 4,
  parameter int LOAD_LAT    = 1,
  parameter int ALU_LAT     = 0,
  parameter int CNT_W       = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  rn,
  input  logic [REG_ADDR_W-1:0]  rm,
  input  logic                   two_src,
  input  logic                   issue_wb,
  input  logic                   issue_mem_read,
  input  logic [REG_ADDR_W-1:0]  issue_dest,
  input  logic                   mem_stall,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [CNT_W-1:0] c_load_lat = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] c_alu_lat  = CNT_W'(ALU_LAT);

  logic [CNT_W-1:0]       r_cnt [NUM_REGS];
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic                   w_rn_busy;
  logic                   w_rm_busy;
  logic                   w_hazard;
  logic                   w_issue;
  logic [CNT_W-1:0]       w_issue_lat;

  // The ID instruction's own destination is deliberately not compared:
  // only older, still-pending writers can block it.
  assign w_rn_busy   = (r_cnt[rn] != '0);
  assign w_rm_busy   = (r_cnt[rm] != '0);
  assign w_hazard    = id_valid & (w_rn_busy | (two_src & w_rm_busy));
  assign w_issue     = id_valid & issue_wb & ~w_hazard & ~mem_stall;
  assign w_issue_lat = issue_mem_read ? c_load_lat : c_alu_lat;

  // Youngest writer wins: a new issue overwrites any pending count, and a
  // zero latency clears the entry outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (!mem_stall) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_issue && (issue_dest == REG_ADDR_W'(i))) begin
          r_cnt[i] <= w_issue_lat;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!mem_stall && w_hazard && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign hazard       = w_hazard;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed, table-driven bench for hazard_scoreboard in three
//            parameterisations sharing one stimulus bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  typedef struct {
    logic       v;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       two;
    logic       wb;
    logic       mr;
    logic [3:0] dest;
    logic       ms;
    logic       hz;
    int         sc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] rn = '0;
  logic [3:0] rm = '0;
  logic       two_src = 1'b0;
  logic       issue_wb = 1'b0;
  logic       issue_mem_read = 1'b0;
  logic [3:0] issue_dest = '0;
  logic       mem_stall = 1'b0;

  logic        hz_def, hz_l3, hz_sat;
  logic [15:0] sc_def, sc_l3;
  logic [3:0]  sc_sat;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard u_def (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rn(rn), .rm(rm),
    .two_src(two_src), .issue_wb(issue_wb), .issue_mem_read(issue_mem_read),
    .issue_dest(issue_dest), .mem_stall(mem_stall),
    .hazard(hz_def), .stall_cycles(sc_def)
  );

  hazard_scoreboard #(.LOAD_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rn(rn), .rm(rm),
    .two_src(two_src), .issue_wb(issue_wb), .issue_mem_read(issue_mem_read),
    .issue_dest(issue_dest), .mem_stall(mem_stall),
    .hazard(hz_l3), .stall_cycles(sc_l3)
  );

  hazard_scoreboard #(.STALL_CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rn(rn), .rm(rm),
    .two_src(two_src), .issue_wb(issue_wb), .issue_mem_read(issue_mem_read),
    .issue_dest(issue_dest), .mem_stall(mem_stall),
    .hazard(hz_sat), .stall_cycles(sc_sat)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input int rn_i, input int rm_i, input logic two,
                     input logic wb, input logic mr, input int dest, input logic ms,
                     input logic hz, input int sc);
    vec_t e;
    e.v = v; e.rn = 4'(rn_i); e.rm = 4'(rm_i); e.two = two; e.wb = wb; e.mr = mr;
    e.dest = 4'(dest); e.ms = ms; e.hz = hz; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; rn = '0; rm = '0; two_src = 1'b0; issue_wb = 1'b0;
    issue_mem_read = 1'b0; issue_dest = '0; mem_stall = 1'b0;
  endtask

  // Mid-cycle asynchronous reset pulse; returns 3 time units after a rising edge.
  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  // sel: 0 = default DUT, 1 = LOAD_LAT=3 DUT, 2 = STALL_CNT_W=4 DUT
  task automatic run_vecs(input string tag, input int sel);
    int act_hz, act_sc;
    for (int i = 0; i < q.size(); i++) begin
      id_valid = q[i].v; rn = q[i].rn; rm = q[i].rm; two_src = q[i].two;
      issue_wb = q[i].wb; issue_mem_read = q[i].mr; issue_dest = q[i].dest;
      mem_stall = q[i].ms;
      #2;
      case (sel)
        0:       begin act_hz = int'(hz_def); act_sc = int'(sc_def); end
        1:       begin act_hz = int'(hz_l3);  act_sc = int'(sc_l3);  end
        default: begin act_hz = int'(hz_sat); act_sc = int'(sc_sat); end
      endcase
      check($sformatf("%s[%0d] hazard", tag, i), act_hz, int'(q[i].hz));
      check($sformatf("%s[%0d] stall_cycles", tag, i), act_sc, q[i].sc);
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  initial begin
    #12 rst = 1'b0;

    do_reset();
    check("reset hazard def", int'(hz_def), 0);
    check("reset stall_cycles def", int'(sc_def), 0);
    check("reset stall_cycles sat", int'(sc_sat), 0);

    // Default latencies: one-cycle load-use stall only.
    //   v  rn rm two wb mr dst ms   hz sc
    add(1, 0, 0, 0, 1, 1, 3, 0,   0, 0);
    add(1, 3, 0, 0, 1, 0, 1, 0,   1, 0);
    add(1, 3, 0, 0, 1, 0, 1, 0,   0, 1);
    add(1, 0, 0, 0, 1, 0, 5, 0,   0, 1);
    add(1, 2, 5, 1, 0, 0, 0, 0,   0, 1);
    add(1, 2, 5, 0, 0, 0, 0, 0,   0, 1);
    add(1, 0, 0, 0, 1, 1, 6, 0,   0, 1);
    add(1, 1, 6, 0, 0, 0, 0, 0,   0, 1);
    add(1, 0, 0, 0, 1, 1, 6, 0,   0, 1);
    add(1, 1, 6, 1, 0, 0, 0, 0,   1, 1);
    add(1, 1, 6, 1, 0, 0, 0, 0,   0, 2);
    add(1, 0, 0, 0, 1, 1, 7, 0,   0, 2);
    add(0, 7, 0, 0, 0, 0, 0, 0,   0, 2);
    add(1, 7, 0, 0, 0, 0, 0, 0,   0, 2);
    add(1, 9, 0, 0, 1, 1, 9, 0,   0, 2);
    add(1, 9, 0, 0, 1, 1, 9, 1,   1, 2);
    add(1, 9, 0, 0, 1, 1, 9, 0,   1, 2);
    add(1, 9, 0, 0, 0, 0, 0, 0,   0, 3);
    add(1, 0, 0, 0, 1, 1, 10, 1,  0, 3);
    add(1, 10, 0, 0, 0, 0, 0, 0,  0, 3);
    add(1, 0, 0, 0, 1, 1, 4, 0,   0, 3);
    add(1, 4, 0, 0, 1, 0, 4, 0,   1, 3);
    add(1, 4, 0, 0, 1, 0, 4, 0,   0, 4);
    add(1, 4, 0, 0, 0, 0, 0, 0,   0, 4);
    run_vecs("def", 0);

    // Asynchronous reset right after a load to r3 has issued.
    id_valid = 1'b1; rn = 4'd0; rm = '0; two_src = 1'b0; issue_wb = 1'b1;
    issue_mem_read = 1'b1; issue_dest = 4'd3; mem_stall = 1'b0;
    @(posedge clk); #1;
    issue_wb = 1'b0; issue_mem_read = 1'b0; rn = 4'd3;
    #1;
    check("pre-reset hazard r3", int'(hz_def), 1);
    rst = 1'b1;
    #1;
    check("async reset hazard", int'(hz_def), 0);
    check("async reset stall_cycles", int'(sc_def), 0);
    rst = 1'b0;
    #1;
    check("post-reset hazard r3", int'(hz_def), 0);
    @(posedge clk); #1;
    #1;
    check("post-reset edge hazard r3", int'(hz_def), 0);

    // LOAD_LAT=3 with a 2-cycle memory freeze, then younger ALU override.
    do_reset();
    add(1, 0, 0, 0, 1, 1, 7, 0,   0, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0,   1, 0);
    add(1, 7, 0, 0, 0, 0, 0, 1,   1, 1);
    add(1, 7, 0, 0, 0, 0, 0, 1,   1, 1);
    add(1, 7, 0, 0, 0, 0, 0, 0,   1, 1);
    add(1, 7, 0, 0, 0, 0, 0, 0,   1, 2);
    add(1, 7, 0, 0, 1, 1, 4, 0,   0, 3);
    add(1, 0, 0, 0, 1, 0, 4, 0,   0, 3);
    add(1, 4, 0, 0, 0, 0, 0, 0,   0, 3);
    run_vecs("lat3", 1);

    // Self-dependent load repeated: hazard on odd cycles, 20 in all.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      add(1, 2, 0, 0, 1, 1, 2, 0, logic'(c % 2), (c / 2 > 15) ? 15 : c / 2);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 15);
    run_vecs("sat", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
